// File: rtl/v_alu_sequencer_pkg.sv
// Shared constants, opcodes and helpers for the vector ALU issue sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package v_alu_sequencer_pkg;

    localparam int VECTOR_LENGTH = 128;
    localparam int VALU_OP_W     = 32;
    localparam int ADDSUB_LAT    = 1;

    localparam int NCHUNK  = VECTOR_LENGTH / VALU_OP_W;
    localparam int VL_W    = $clog2(VECTOR_LENGTH / 8) + 1;
    localparam int CHUNK_W = $clog2(NCHUNK + 1);
    localparam int BE_W    = VALU_OP_W / 8;
    // Capture pipe keeps at least one stage so the arrays never collapse to zero width.
    localparam int PIPE_D  = (ADDSUB_LAT > 0) ? ADDSUB_LAT : 1;
    localparam int LAT_W   = $clog2(PIPE_D + 1);

    localparam logic [3:0] VALU_NOP  = 4'h0;
    localparam logic [3:0] VALU_VADD = 4'h1;
    localparam logic [3:0] VALU_VSUB = 4'h2;
    localparam logic [3:0] VALU_VAND = 4'h3;
    localparam logic [3:0] VALU_VOR  = 4'h4;
    localparam logic [3:0] VALU_VXOR = 4'h5;

    localparam logic [1:0] VSEW_8  = 2'd0;
    localparam logic [1:0] VSEW_16 = 2'd1;
    localparam logic [1:0] VSEW_32 = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAIN,
        SEQ_WB
    } seq_state_t;

    // Adder ops go through the registered adder; logic ops are combinational.
    function automatic logic [LAT_W-1:0] valu_latency(input logic [3:0] op);
        return ((op == VALU_VADD) || (op == VALU_VSUB)) ? LAT_W'(ADDSUB_LAT) : '0;
    endfunction

    function automatic logic valu_op_supported(input logic [3:0] op);
        return (op == VALU_VADD) || (op == VALU_VSUB) || (op == VALU_VAND) ||
               (op == VALU_VOR)  || (op == VALU_VXOR);
    endfunction

endpackage

// File: rtl/v_alu_sequencer_if.sv
// Request, ALU-side and writeback signals of the vector ALU sequencer.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side, wb_valid/wb_ready on writeback.
interface v_alu_sequencer_if;
    import v_alu_sequencer_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    logic [3:0]               op_instr;
    logic [1:0]               vsew;
    logic [VL_W-1:0]          vl;
    logic [VECTOR_LENGTH-1:0] vs1_data;
    logic [VECTOR_LENGTH-1:0] vs2_data;
    logic [VECTOR_LENGTH-1:0] vd_old;

    logic [3:0]               alu_op_instr;
    logic [1:0]               alu_vsew;
    logic [VALU_OP_W-1:0]     alu_op_A;
    logic [VALU_OP_W-1:0]     alu_op_B;
    logic [VALU_OP_W-1:0]     alu_result;

    logic                     wb_valid;
    logic [VECTOR_LENGTH-1:0] wb_data;
    logic                     wb_ready;

    // Integration side: issues instructions, hosts the ALU, consumes writeback.
    modport master (
        output req_valid, op_instr, vsew, vl, vs1_data, vs2_data, vd_old,
        output alu_result, wb_ready,
        input  req_ready, alu_op_instr, alu_vsew, alu_op_A, alu_op_B,
        input  wb_valid, wb_data
    );

    // Sequencer side.
    modport slave (
        input  req_valid, op_instr, vsew, vl, vs1_data, vs2_data, vd_old,
        input  alu_result, wb_ready,
        output req_ready, alu_op_instr, alu_vsew, alu_op_A, alu_op_B,
        output wb_valid, wb_data
    );

endinterface

// File: rtl/v_alu_sequencer_elem_byte_en.sv
// Byte enables for one ALU-width chunk: a byte is live when its element index is below vl.
// Latency: combinational.
// Backpressure: none.
module v_elem_byte_en
    import v_alu_sequencer_pkg::*;
(
    input  logic [VL_W-1:0]    vl,
    input  logic [1:0]         vsew,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [BE_W-1:0]    byte_en
);

    logic [7:0] byte_idx;
    logic [7:0] elem_idx;

    // Element index of a byte is its absolute byte index divided by the element size in bytes.
    always_comb begin
        byte_en  = '0;
        byte_idx = '0;
        elem_idx = '0;
        for (int b = 0; b < BE_W; b++) begin
            byte_idx   = 8'(int'(chunk) * BE_W + b);
            elem_idx   = byte_idx >> vsew;
            byte_en[b] = (elem_idx < 8'(vl));
        end
    end

endmodule

// File: rtl/v_alu_sequencer.sv
// Vector ALU issue sequencer: slices vs1/vs2 into ALU chunks, captures results, merges tail from vd_old.
// Latency: nchunk+L edges after the accepting edge to wb_valid; wb_valid right after accept if nothing issues.
// Backpressure: WB holds wb_valid/wb_data until wb_ready; req_ready is high only in IDLE.
module v_alu_sequencer
    import v_alu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    v_alu_sequencer_if.slave seq
);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [3:0]               op_q;
    logic [1:0]               vsew_q;
    logic [VL_W-1:0]          vl_q;
    logic [CHUNK_W-1:0]       nchunk_q;
    logic [LAT_W-1:0]         lat_q;
    logic [VECTOR_LENGTH-1:0] vs1_q;
    logic [VECTOR_LENGTH-1:0] vs2_q;
    logic [VECTOR_LENGTH-1:0] wb_data_q;
    logic [CHUNK_W-1:0]       chunk_cnt;

    logic [PIPE_D-1:0]        pipe_vld;
    logic [CHUNK_W-1:0]       pipe_idx [PIPE_D];

    logic [VL_W-1:0]          vlmax;
    logic [VL_W-1:0]          vl_clamp;
    logic [7:0]               byte_cnt;
    logic [CHUNK_W-1:0]       nchunk_req;
    logic                     req_ok;
    logic                     accept;
    logic                     issue_fire;
    logic                     last_issue;
    logic                     pipe_drained;
    logic                     cap_vld;
    logic [CHUNK_W-1:0]       cap_idx;
    logic [BE_W-1:0]          cap_be;

    // Request decode: clamp vl to VLMAX and size the job in ALU chunks.
    // Reserved SEW encodings take the same no-issue path as unsupported opcodes.
    always_comb begin
        vlmax      = VL_W'((VECTOR_LENGTH / 8) >> seq.vsew);
        vl_clamp   = (seq.vl > vlmax) ? vlmax : seq.vl;
        byte_cnt   = 8'(vl_clamp) << seq.vsew;
        nchunk_req = CHUNK_W'((byte_cnt + 8'(BE_W - 1)) >> $clog2(BE_W));
        req_ok     = valu_op_supported(seq.op_instr) && (seq.vsew <= VSEW_32) &&
                     (nchunk_req != '0);
        accept     = seq.req_valid && (state == SEQ_IDLE);
    end

    // Issue tracking and result capture select: L=0 ops capture in the issue cycle itself,
    // adder ops capture from the tail of the valid/index pipe.
    always_comb begin
        issue_fire   = (state == SEQ_ISSUE);
        last_issue   = issue_fire && (chunk_cnt == (nchunk_q - CHUNK_W'(1)));
        pipe_drained = ((pipe_vld & ~(PIPE_D'(1) << (PIPE_D - 1))) == '0);
        cap_vld      = (lat_q == '0) ? issue_fire : pipe_vld[PIPE_D-1];
        cap_idx      = (lat_q == '0) ? chunk_cnt  : pipe_idx[PIPE_D-1];
    end

    v_elem_byte_en u_byte_en (
        .vl      (vl_q),
        .vsew    (vsew_q),
        .chunk   (cap_idx),
        .byte_en (cap_be)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DRAIN exits once the only chunk left in the pipe is the one captured this edge.
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE: begin
                if (accept) begin
                    state_nxt = req_ok ? SEQ_ISSUE : SEQ_WB;
                end
            end
            SEQ_ISSUE: begin
                if (last_issue) begin
                    state_nxt = (lat_q != '0) ? SEQ_DRAIN : SEQ_WB;
                end
            end
            SEQ_DRAIN: begin
                if (pipe_drained) begin
                    state_nxt = SEQ_WB;
                end
            end
            SEQ_WB: begin
                if (seq.wb_ready) begin
                    state_nxt = SEQ_IDLE;
                end
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    // Outputs: ALU sees NOP outside ISSUE/DRAIN so its adder stays idle; operands only in ISSUE.
    always_comb begin
        seq.req_ready    = (state == SEQ_IDLE);
        seq.wb_valid     = (state == SEQ_WB);
        seq.wb_data      = wb_data_q;
        seq.alu_op_instr = VALU_NOP;
        seq.alu_vsew     = '0;
        seq.alu_op_A     = '0;
        seq.alu_op_B     = '0;
        if ((state == SEQ_ISSUE) || (state == SEQ_DRAIN)) begin
            seq.alu_op_instr = op_q;
            seq.alu_vsew     = vsew_q;
        end
        if (state == SEQ_ISSUE) begin
            seq.alu_op_A = vs1_q[chunk_cnt*VALU_OP_W +: VALU_OP_W];
            seq.alu_op_B = vs2_q[chunk_cnt*VALU_OP_W +: VALU_OP_W];
        end
    end

    // Datapath: latch the request, step the chunk counter, shift the capture pipe, merge results.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= VALU_NOP;
            vsew_q    <= '0;
            vl_q      <= '0;
            nchunk_q  <= '0;
            lat_q     <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            wb_data_q <= '0;
            chunk_cnt <= '0;
            pipe_vld  <= '0;
            for (int i = 0; i < PIPE_D; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_q      <= seq.op_instr;
                vsew_q    <= seq.vsew;
                vl_q      <= vl_clamp;
                nchunk_q  <= nchunk_req;
                lat_q     <= valu_latency(seq.op_instr);
                vs1_q     <= seq.vs1_data;
                vs2_q     <= seq.vs2_data;
                wb_data_q <= seq.vd_old;
                chunk_cnt <= '0;
            end else if (issue_fire) begin
                chunk_cnt <= chunk_cnt + CHUNK_W'(1);
            end

            pipe_vld[0] <= issue_fire && (lat_q != '0);
            pipe_idx[0] <= chunk_cnt;
            for (int i = 1; i < PIPE_D; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            // Tail bytes (element index >= vl) keep the vd_old value preloaded on accept.
            if (cap_vld) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (cap_be[b]) begin
                        wb_data_q[cap_idx*VALU_OP_W + b*8 +: 8] <= seq.alu_result[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule
